// File: rtl/bcd_display_pkg.sv
// Shared constants and types for the multiplexed BCD seven-segment display driver.
// Glyphs are active-low {g,f,e,d,c,b,a} for a common-anode display.
package bcd_display_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000   // 9
   };

   // One full display image: four packed BCD digits plus their decimal points.
   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] digits;
      logic [NUM_DIGITS-1:0]   dp;
   } disp_word_t;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Data/control bundle between a BCD value source and the display scanner.
// master drives the value and controls; slave (the scanner) drives the display pins.
interface bcd_display_scan_if;
   logic        enable;
   logic        update;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp_n;
   logic        frame_start;

   modport master (
      output enable, update, digits_in, dp_in, blank_lz,
      input  an, seg, dp_n, frame_start
   );

   modport slave (
      input  enable, update, digits_in, dp_in, blank_lz,
      output an, seg, dp_n, frame_start
   );
endinterface

// File: rtl/bcd_to_sevenseg.sv
// Combinational BCD to active-low seven-segment decode; non-decimal codes show a dash.
module bcd_to_sevenseg
   import bcd_display_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (blank) begin
         seg = SEG_BLANK;
      end else if (bcd <= 4'd9) begin
         seg = SEG_DIGIT[bcd];
      end
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 4-digit common-anode display scanner with frame-synchronous
// value update, inter-digit blanking and leading-zero suppression.
module bcd_display_scan
   import bcd_display_pkg::*;
#(
   parameter int unsigned CLK_DIV = 100000,
   parameter int unsigned BLANK   = 16
) (
   input  logic clock,
   input  logic reset_n,
   bcd_display_scan_if.slave bus
);

   localparam int PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK);

   logic [PW-1:0] presc_reg;
   logic [1:0]    index_reg;
   disp_word_t    staging_reg;
   disp_word_t    shadow_reg;
   logic          pending_reg;
   logic          started_reg;

   logic [3:0]    an_reg;
   logic [6:0]    seg_reg;
   logic          dp_n_reg;
   logic          frame_start_reg;

   logic          tick;
   logic          wrap;
   disp_word_t    input_word;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic [6:0]    dec_seg [NUM_DIGITS];
   logic [6:0]    seg_next;

   assign tick       = bus.enable && (presc_reg == PRESC_LAST);
   assign wrap       = tick && (index_reg == 2'd3);
   assign input_word = '{digits: bus.digits_in, dp: bus.dp_in};

   // A digit blanks only when it is zero and everything above it is blanked too,
   // so the chain starts at the MSD; digit 0 always shows.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic [3:0] digit;
         assign digit = shadow_reg.digits[4*gi +: 4];

         if (gi == 0) begin : g_lsd
            assign lz_blank[gi] = 1'b0;
         end else if (gi == NUM_DIGITS - 1) begin : g_msd
            assign lz_blank[gi] = bus.blank_lz && (digit == 4'd0);
         end else begin : g_mid
            assign lz_blank[gi] = lz_blank[gi+1] && (digit == 4'd0);
         end

         bcd_to_sevenseg u_dec (
            .bcd   (digit),
            .blank (lz_blank[gi]),
            .seg   (dec_seg[gi])
         );
      end
   endgenerate

   assign seg_next = dec_seg[index_reg];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         presc_reg       <= '0;
         index_reg       <= 2'd0;
         staging_reg     <= '0;
         shadow_reg      <= '0;
         pending_reg     <= 1'b0;
         started_reg     <= 1'b0;
         an_reg          <= 4'b1111;
         seg_reg         <= SEG_BLANK;
         dp_n_reg        <= 1'b1;
         frame_start_reg <= 1'b0;
      end else begin
         if (bus.enable) begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
         end
         if (tick) begin
            index_reg <= index_reg + 2'd1;
         end

         if (bus.update) begin
            staging_reg <= input_word;
         end
         // Shadow only changes at the frame boundary so a rippling carry never tears.
         if (wrap) begin
            pending_reg <= 1'b0;
            if (bus.update) begin
               shadow_reg <= input_word;
            end else if (pending_reg) begin
               shadow_reg <= staging_reg;
            end
         end else if (bus.update) begin
            pending_reg <= 1'b1;
         end

         started_reg <= started_reg | bus.enable;

         if (!bus.enable) begin
            an_reg   <= 4'b1111;
            seg_reg  <= SEG_BLANK;
            dp_n_reg <= 1'b1;
         end else begin
            an_reg   <= (presc_reg < BLANK_END) ? 4'b1111 : ~(4'b0001 << index_reg);
            seg_reg  <= seg_next;
            dp_n_reg <= ~shadow_reg.dp[index_reg];
         end
         frame_start_reg <= wrap | (bus.enable & ~started_reg);
      end
   end

   assign bus.an          = an_reg;
   assign bus.seg         = seg_reg;
   assign bus.dp_n        = dp_n_reg;
   assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: a cycle-count based display model checked every cycle,
// plus directed scenarios with hand-computed glyph and anode expectations.
module tb_bcd_display_scan;

   localparam int CLK_DIV = 8;
   localparam int BLANK   = 2;
   localparam int FRAME   = 4 * CLK_DIV;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   bcd_display_scan_if bus ();

   bcd_display_scan #(.CLK_DIV(CLK_DIV), .BLANK(BLANK)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model state: n counts enabled cycles since reset; slot position and digit follow from it.
   int          n_m        = 0;
   logic [15:0] shadow_d_m = '0;
   logic [3:0]  shadow_p_m = '0;
   logic [15:0] stage_d_m  = '0;
   logic [3:0]  stage_p_m  = '0;
   bit          pending_m  = 1'b0;
   logic [3:0]  exp_an     = 4'hF;
   logic [6:0]  exp_seg    = 7'h7F;
   logic        exp_dp     = 1'b1;
   logic        exp_fs     = 1'b0;
   bit          exp_seg_chk = 1'b1;
   int          m_pos, m_idx;
   bit          m_wrap;

   function automatic logic [6:0] glyph(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic logic [6:0] shown(input logic [15:0] w, input int k, input bit lz);
      bit all_zero;
      all_zero = 1'b1;
      for (int j = k; j < 4; j++) begin
         if (w[4*j +: 4] != 4'd0) all_zero = 1'b0;
      end
      if (lz && k > 0 && all_zero) return 7'b1111111;
      return glyph(int'(w[4*k +: 4]));
   endfunction

   always @(posedge clock) begin
      if (!reset_n) begin
         n_m = 0; shadow_d_m = '0; shadow_p_m = '0; stage_d_m = '0; stage_p_m = '0;
         pending_m = 1'b0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0; exp_seg_chk = 1'b1;
      end else begin
         m_pos  = n_m % CLK_DIV;
         m_idx  = (n_m / CLK_DIV) % 4;
         m_wrap = bus.enable && (n_m % FRAME == FRAME - 1);
         if (!bus.enable) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0; exp_seg_chk = 1'b1;
         end else begin
            exp_an      = (m_pos < BLANK) ? 4'hF : ~(4'b0001 << m_idx);
            exp_seg     = shown(shadow_d_m, m_idx, bus.blank_lz);
            exp_dp      = ~shadow_p_m[m_idx];
            exp_fs      = (n_m == 0) || m_wrap;
            exp_seg_chk = (m_pos >= BLANK);
         end
         if (m_wrap) begin
            if (bus.update) begin
               shadow_d_m = bus.digits_in; shadow_p_m = bus.dp_in;
            end else if (pending_m) begin
               shadow_d_m = stage_d_m; shadow_p_m = stage_p_m;
            end
            pending_m = 1'b0;
         end
         if (bus.update) begin
            stage_d_m = bus.digits_in; stage_p_m = bus.dp_in;
            if (!m_wrap) pending_m = 1'b1;
         end
         if (bus.enable) n_m++;
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(negedge clock);
      chk("model an", 16'(bus.an), 16'(exp_an));
      chk("model frame_start", 16'(bus.frame_start), 16'(exp_fs));
      if (exp_seg_chk) begin
         chk("model seg", 16'(bus.seg), 16'(exp_seg));
         chk("model dp_n", 16'(bus.dp_n), 16'(exp_dp));
      end
   endtask

   // Waits for the next fresh appearance of an anode pattern.
   task automatic wait_an(input logic [3:0] target);
      int k;
      k = 0;
      while (bus.an == target && k < 100) begin step(); k++; end
      while (bus.an != target && k < 100) begin step(); k++; end
      chk("wait_an reached", 16'(bus.an), 16'(target));
   endtask

   task automatic see(input string name, input logic [3:0] an_pat, input logic [6:0] seg_v,
                      input logic dp_v);
      wait_an(an_pat);
      chk({name, " seg"}, 16'(bus.seg), 16'(seg_v));
      chk({name, " dp_n"}, 16'(bus.dp_n), 16'(dp_v));
   endtask

   initial begin
      logic [3:0] ean;
      int k;
      bus.enable = 1'b0; bus.update = 1'b0; bus.digits_in = '0; bus.dp_in = '0;
      bus.blank_lz = 1'b0;
      repeat (3) step();
      chk("reset an", 16'(bus.an), 16'h000F);
      chk("reset seg", 16'(bus.seg), 16'h007F);
      chk("reset dp_n", 16'(bus.dp_n), 16'h0001);
      chk("reset frame_start", 16'(bus.frame_start), 16'h0000);
      reset_n = 1'b1;
      step();
      bus.enable = 1'b1;
      step();
      chk("first frame_start", 16'(bus.frame_start), 16'h0001);

      // Idle value, without and with leading-zero suppression
      see("idle d0", 4'b1110, 7'h40, 1'b1);
      see("idle d1", 4'b1101, 7'h40, 1'b1);
      see("idle d2", 4'b1011, 7'h40, 1'b1);
      see("idle d3", 4'b0111, 7'h40, 1'b1);
      bus.blank_lz = 1'b1;
      see("lz d1", 4'b1101, 7'h7F, 1'b1);
      see("lz d2", 4'b1011, 7'h7F, 1'b1);
      see("lz d3", 4'b0111, 7'h7F, 1'b1);
      see("lz d0", 4'b1110, 7'h40, 1'b1);
      bus.blank_lz = 1'b0;

      // Mid-frame update is deferred to the frame boundary
      wait_an(4'b1101);
      bus.digits_in = 16'h1234; bus.dp_in = 4'b0100; bus.update = 1'b1;
      step();
      bus.update = 1'b0;
      chk("deferred d1 seg", 16'(bus.seg), 16'h0040);
      see("1234 d0", 4'b1110, 7'h19, 1'b1);
      see("1234 d1", 4'b1101, 7'h30, 1'b1);
      see("1234 d2", 4'b1011, 7'h24, 1'b0);
      see("1234 d3", 4'b0111, 7'h79, 1'b1);

      // Two updates in one frame: last one wins
      wait_an(4'b1110);
      bus.digits_in = 16'h0099; bus.dp_in = 4'b0000; bus.update = 1'b1;
      step();
      bus.update = 1'b0;
      step();
      bus.digits_in = 16'h0100; bus.update = 1'b1;
      step();
      bus.update = 1'b0;
      bus.blank_lz = 1'b1;
      see("0100 d0", 4'b1110, 7'h40, 1'b1);
      see("0100 d1", 4'b1101, 7'h40, 1'b1);
      see("0100 d2", 4'b1011, 7'h79, 1'b1);
      see("0100 d3", 4'b0111, 7'h7F, 1'b1);

      // Update on the wrap tick lands in the very next frame
      wait_an(4'b0111);
      repeat (4) step();
      bus.digits_in = 16'h00A5; bus.update = 1'b1;
      step();
      bus.update = 1'b0;
      chk("wrap frame_start", 16'(bus.frame_start), 16'h0001);
      chk("pending cleared", 16'(dut.pending_reg), 16'h0000);
      see("00A5 d0", 4'b1110, 7'h12, 1'b1);
      see("00A5 d1", 4'b1101, 7'h3F, 1'b1);
      see("00A5 d2", 4'b1011, 7'h7F, 1'b1);
      see("00A5 d3", 4'b0111, 7'h7F, 1'b1);

      // Slot timing over one whole frame, starting at frame_start
      k = 0;
      while (bus.frame_start !== 1'b1 && k < 100) begin step(); k++; end
      chk("frame_start found", 16'(bus.frame_start), 16'h0001);
      for (int c = 1; c <= FRAME; c++) begin
         step();
         ean = (((c - 1) % CLK_DIV) < BLANK) ? 4'hF : ~(4'b0001 << ((c - 1) / CLK_DIV));
         chk("slot an", 16'(bus.an), 16'(ean));
         chk("frame_start period", 16'(bus.frame_start), (c == FRAME) ? 16'h0001 : 16'h0000);
      end

      // Enable low for 5 cycles mid-slot 2, scanning resumes in slot 2
      wait_an(4'b1011);
      repeat (2) step();
      bus.enable = 1'b0;
      step();
      chk("disabled an", 16'(bus.an), 16'h000F);
      chk("disabled seg", 16'(bus.seg), 16'h007F);
      repeat (4) step();
      bus.enable = 1'b1;
      step();
      chk("resume slot 2", 16'(bus.an), 16'h000B);

      // Asynchronous reset mid-slot 2 drops pending data
      wait_an(4'b1011);
      bus.digits_in = 16'h9999; bus.update = 1'b1;
      step();
      bus.update = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("async reset an", 16'(bus.an), 16'h000F);
      chk("async reset seg", 16'(bus.seg), 16'h007F);
      chk("async reset dp_n", 16'(bus.dp_n), 16'h0001);
      chk("async reset frame_start", 16'(bus.frame_start), 16'h0000);
      repeat (2) step();
      reset_n = 1'b1;
      step();
      wait_an(4'b1110);
      wait_an(4'b1110);
      chk("post-reset d0 seg", 16'(bus.seg), 16'h0040);
      see("post-reset d3", 4'b0111, 7'h7F, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Time-multiplexed 4-digit seven-segment display driver; the consuming end of the team's 2-digit BCD counters, which are chained into a 4-digit value. Latches a 16-bit packed BCD word under an update strobe. Applies it only at frame boundaries, so a carry that ripples through digits never shows as a torn value. Drives the board's common-anode display with active-low anodes and segments, inter-digit blanking, and leading-zero suppression.

## Interface
- CLK_DIV, 100000: clock cycles per digit slot; must be ≥ BLANK+2; 1 kHz per digit at a 100 MHz clock.
- BLANK, 16: cycles at the start of each slot with all anodes off, for anti-ghosting.
- clock  in  1  system clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low, scanning freezes and all anodes go off.
- update  in  1  single-cycle strobe; samples digits_in and dp_in.
- digits_in  in  16  packed BCD; [15:12] is digit 3 (MSD), [3:0] is digit 0.
- dp_in  in  4  decimal point request per digit, active-high.
- blank_lz  in  1  enables leading-zero suppression (level, sampled live).
- an  out  4  anode enables, active-low; an[0] is digit 0.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

## Operation
- Prescaler: counts 0..CLK_DIV-1 while enable=1. The cycle at CLK_DIV-1 is a tick. The prescaler holds its value while enable=0.
- Digit index (2 bits): advances on each tick in the order 0→1→2→3→0.
- Staging: update=1 loads staging←{digits_in, dp_in} and sets pending. A later update before the frame boundary overwrites staging; the last one wins.
- Frame boundary: the tick on which the index wraps 3→0. If pending, shadow←staging and pending clears.
  - Update coinciding with the wrap tick: the new inputs go straight to shadow and pending ends cleared.
- Decode of shadow[index]:
  - 0–9: standard glyphs. 0=1000000, 1=1111001, 8=0000000.
  - Codes A–F: dash, 0111111.
- Leading-zero blanking (blank_lz=1): digit k in 3..1 shows blank (1111111) if it is 0 and every higher digit is also blanked. Digit 0 is never blanked. dp still shows on a blanked digit.
- Anodes:
  - Within a slot where prescaler < BLANK: an=1111.
  - Otherwise: an has a single zero at position index.
  - enable=0: an=1111, seg=1111111, dp_n=1.
- frame_start asserts for the one cycle after the wrap tick, and on the first enabled cycle after reset.

## Timing
- Reset values:
  - an=1111, seg=1111111, dp_n=1, frame_start=0.
  - index=0, prescaler=0.
  - shadow=0, staging=0, pending=0.
- All outputs are registered, one cycle after the internal index, prescaler and shadow state.
- Update-to-display latency: from the update edge to the next frame boundary, worst case 4·CLK_DIV cycles, plus one output cycle.
- Anode-on duty per slot: CLK_DIV−BLANK cycles.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous). Pending data is lost.
- enable deasserted mid-slot: outputs go blank on the next cycle. On re-enable, scanning resumes at the held prescaler and index values.

## Structure
- Package bcd_display_pkg:
  - SEG_BLANK, SEG_DASH and the SEG_DIGIT[0:9] glyph constants.
  - NUM_DIGITS=4.
- Sub-module bcd_to_sevenseg: combinational 4-bit BCD to 7-bit active-low decode, with a blank input.
- Top level holds the prescaler, index, staging/pending/shadow registers, blanking logic and output registers.

## Test plan
Run all scenarios with CLK_DIV=8, BLANK=2.
- Reset then enable, no update → slot 0 shows an=1110 with seg=1000000; digits 1–3 show '0' with blank_lz=0, and are blank with blank_lz=1.
- update with digits_in=16'h1234, dp_in=0100 mid-frame → display unchanged until the wrap. Next frame shows 4,3,2,1 across an[0..3], with dp_n=0 only in slot 2.
- Updates of 16'h0099 then 16'h0100 within one frame → only 0100 is ever displayed. With blank_lz=1, digit 3 is blank and digit 2 shows 1.
- update 16'h00A5 coinciding with the wrap tick → the same frame shows 5 and a dash; pending=0 afterward.
- Check every slot → an=1111 for exactly 2 cycles, then a single active anode for 6 cycles; frame_start has a period of 32 cycles.
- reset_n low mid-slot 2, and enable toggled low for 5 cycles → outputs go to reset values asynchronously. After the enable toggle, scanning resumes at the held index with no skipped slot.
